// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one UART transmitter among NUM_REQ byte requesters; ARB_TIMEOUT_EN adds a sticky watchdog.
// Latency: request seen in IDLE -> GRANT next cycle -> load strobe and req_ack one cycle later; requesters hold until acked.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int IDW            = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ack,
  output logic [7:0]           uart_tx_data,
  output logic                 uart_tx_ready,
  input  logic                 uart_tx_done,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_err
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || IDW != $clog2(NUM_REQ) ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("uart_tx_arbiter: illegal parameter set");
  end

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    LOAD,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t         state, state_nxt;
  logic           done_meta, done_s;
  logic [IDW-1:0] ptr, ptr_nxt;
  logic           found;
  logic [IDW-1:0] win;
  logic [IDW:0]   idx;
  logic           to_hit;

  // Synchroniser resets to "done" so an idle UART is assumed after reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      done_meta <= 1'b1;
      done_s    <= 1'b1;
    end else begin
      done_meta <= uart_tx_done;
      done_s    <= done_meta;
    end
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + (IDW+1)'(i);
      if (idx >= (IDW+1)'(NUM_REQ)) idx = idx - (IDW+1)'(NUM_REQ);
      if (!found && req_valid[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  assign ptr_nxt = (win == IDW'(NUM_REQ-1)) ? '0 : win + 1'b1;

`ifdef ARB_TIMEOUT_EN
  logic [15:0] to_cnt;

  assign to_hit = (state == WAIT_BUSY || state == WAIT_DONE) &&
                  (to_cnt == 16'(TIMEOUT_CYCLES - 1));

  // Counter is cleared while leaving LOAD, i.e. on entry to WAIT_BUSY.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state == LOAD)
        to_cnt <= '0;
      else if (state == WAIT_BUSY || state == WAIT_DONE)
        to_cnt <= to_cnt + 16'd1;
      if (to_hit)
        timeout_err <= 1'b1;
    end
  end
`else
  assign to_hit      = 1'b0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (done_s && |req_valid) state_nxt = GRANT;
      GRANT:     state_nxt = found ? LOAD : IDLE;
      LOAD:      state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (!done_s) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
    if (to_hit) state_nxt = IDLE;
  end

  // Outputs are registered from next-state so the load strobe is glitch-free.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      ptr           <= '0;
      req_ack       <= '0;
      uart_tx_ready <= 1'b0;
      busy          <= 1'b0;
      grant_id      <= '0;
      uart_tx_data  <= '0;
    end else begin
      state         <= state_nxt;
      uart_tx_ready <= (state_nxt == LOAD);
      busy          <= (state_nxt != IDLE);
      req_ack       <= '0;
      if (state == GRANT && found) begin
        req_ack[win] <= 1'b1;
        uart_tx_data <= req_data[8*win +: 8];
        grant_id     <= win;
        ptr          <= ptr_nxt;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural UART done model.
module tb_uart_tx_arbiter;

  logic        clock;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ack;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_ready;
  logic        uart_tx_done;
  logic        busy;
  logic [1:0]  grant_id;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;
  bit hang   = 1'b0;

  logic [1:0] gq[$];
  logic [7:0] dq[$];
  logic [3:0] aq[$];
  int         tq[$];
  int         cyc      = 0;
  int         ready_hi = 0;
  int         ack_hi   = 0;
  logic       prev_ready = 1'b0;

  uart_tx_arbiter #(.NUM_REQ(4), .IDW(2), .TIMEOUT_CYCLES(100)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ack(req_ack), .uart_tx_data(uart_tx_data), .uart_tx_ready(uart_tx_ready),
    .uart_tx_done(uart_tx_done), .busy(busy), .grant_id(grant_id),
    .timeout_err(timeout_err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // UART model: done falls 2 clocks after a strobe, rises 40 clocks later.
  initial begin
    uart_tx_done = 1'b1;
    forever begin
      @(negedge clock);
      if (uart_tx_ready === 1'b1) begin
        repeat (2) @(posedge clock);
        #1 uart_tx_done = 1'b0;
        if (!hang) begin
          repeat (40) @(posedge clock);
          #1 uart_tx_done = 1'b1;
        end
      end
    end
  end

  always @(negedge clock) begin
    cyc = cyc + 1;
    if (uart_tx_ready && !prev_ready) begin
      gq.push_back(grant_id);
      dq.push_back(uart_tx_data);
      aq.push_back(req_ack);
      tq.push_back(cyc);
    end
    if (uart_tx_ready) ready_hi = ready_hi + 1;
    if (req_ack != 4'b0) ack_hi = ack_hi + 1;
    prev_ready = uart_tx_ready;
  end

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #2 reset = 1'b1;
    @(posedge clock);
    #2;
  endtask

  task automatic wait_strobes(input int target, input logic [3:0] drop, input int budget);
    int n = 0;
    while (gq.size() < target && n < budget) begin
      @(posedge clock);
      #2 req_valid = req_valid & ~(req_ack & drop);
      n++;
    end
    checks++;
    if (gq.size() < target) begin
      errors++;
      $display("FAIL strobe_wait: got %0d strobes, need %0d", gq.size(), target);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(posedge clock);
      #2 n++;
    end while (busy !== 1'b0 && n < budget);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_wait: busy=%b after %0d cycles, need 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    req_valid = 4'b0;
    req_data = 32'h0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: %b need 0", busy); end
    checks++; if (uart_tx_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: %b need 0", uart_tx_ready); end
    checks++; if (req_ack !== 4'b0) begin errors++; $display("FAIL rst_ack: %b need 0000", req_ack); end
    checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rst_grant: %0d need 0", grant_id); end
    checks++; if (uart_tx_data !== 8'h00) begin errors++; $display("FAIL rst_data: %h need 00", uart_tx_data); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout: %b need 0", timeout_err); end
    @(posedge clock);
    #2 reset = 1'b1;
    repeat (2) @(posedge clock);
    #2;
  endtask

  task automatic test_single();
    int base  = gq.size();
    int rbase = ready_hi;
    int abase = ack_hi;
    req_data[7:0] = 8'h55;
    req_valid = 4'b0001;
    @(posedge clock); #2;
    checks++; if (busy !== 1'b1 || req_ack !== 4'b0) begin errors++; $display("FAIL single_grant_cycle: busy=%b ack=%b need 1/0000", busy, req_ack); end
    @(posedge clock); #2;
    checks++; if (req_ack !== 4'b0001) begin errors++; $display("FAIL single_ack: %b need 0001", req_ack); end
    checks++; if (uart_tx_ready !== 1'b1) begin errors++; $display("FAIL single_ready: %b need 1", uart_tx_ready); end
    checks++; if (uart_tx_data !== 8'h55) begin errors++; $display("FAIL single_data: %h need 55", uart_tx_data); end
    req_valid = 4'b0000;
    @(posedge clock); #2;
    checks++; if (req_ack !== 4'b0 || uart_tx_ready !== 1'b0) begin errors++; $display("FAIL single_pulse_width: ack=%b ready=%b need 0000/0", req_ack, uart_tx_ready); end
    repeat (20) @(posedge clock); #2;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_mid: %b need 1", busy); end
    wait_idle(200);
    checks++; if (gq.size() != base + 1) begin errors++; $display("FAIL single_strobes: %0d need %0d", gq.size(), base + 1); end
    checks++; if (ready_hi != rbase + 1 || ack_hi != abase + 1) begin errors++; $display("FAIL single_hi_cycles: ready=%0d ack=%0d need 1/1", ready_hi - rbase, ack_hi - abase); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id[5]   = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [7:0] exp_dat[5]  = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    int base;
    int rbase;
    int abase;
    apply_reset();
    base  = gq.size();
    rbase = ready_hi;
    abase = ack_hi;
    req_data  = 32'hA3A2A1A0;
    req_valid = 4'b1111;
    wait_strobes(base + 5, 4'b0000, 400);
    req_valid = 4'b0000;
    wait_idle(200);
    for (int k = 0; k < 5; k++) begin
      if (base + k < gq.size()) begin
        checks++; if (gq[base+k] !== exp_id[k]) begin errors++; $display("FAIL rr_id[%0d]: %0d need %0d", k, gq[base+k], exp_id[k]); end
        checks++; if (dq[base+k] !== exp_dat[k]) begin errors++; $display("FAIL rr_data[%0d]: %h need %h", k, dq[base+k], exp_dat[k]); end
        checks++; if (aq[base+k] !== (4'b0001 << exp_id[k])) begin errors++; $display("FAIL rr_ack[%0d]: %b need %b", k, aq[base+k], 4'b0001 << exp_id[k]); end
      end
      if (k > 0 && base + k < tq.size()) begin
        checks++; if (tq[base+k] - tq[base+k-1] < 40) begin errors++; $display("FAIL rr_gap[%0d]: %0d cycles need >=40", k, tq[base+k] - tq[base+k-1]); end
      end
    end
    checks++; if (ready_hi - rbase != 5 || ack_hi - abase != 5) begin errors++; $display("FAIL rr_hi_cycles: ready=%0d ack=%0d need 5/5", ready_hi - rbase, ack_hi - abase); end
  endtask

  task automatic test_pointer_wrap();
    int base = gq.size();
    req_data[31:24] = 8'hB3;
    req_valid = 4'b1000;
    wait_strobes(base + 1, 4'b1000, 100);
    wait_idle(200);
    req_data[15:8] = 8'hB1;
    req_valid = 4'b1010;
    wait_strobes(base + 3, 4'b1010, 200);
    wait_idle(200);
    if (gq.size() >= base + 3) begin
      checks++; if (gq[base] !== 2'd3) begin errors++; $display("FAIL wrap_first: %0d need 3", gq[base]); end
      checks++; if (gq[base+1] !== 2'd1 || dq[base+1] !== 8'hB1) begin errors++; $display("FAIL wrap_second: id=%0d data=%h need 1/B1", gq[base+1], dq[base+1]); end
      checks++; if (gq[base+2] !== 2'd3 || dq[base+2] !== 8'hB3) begin errors++; $display("FAIL wrap_third: id=%0d data=%h need 3/B3", gq[base+2], dq[base+2]); end
    end
  endtask

  task automatic test_withdrawn();
    int base  = gq.size();
    int abase = ack_hi;
    req_data[7:0]   = 8'h5A;
    req_data[23:16] = 8'hEE;
    req_valid = 4'b0001;
    wait_strobes(base + 1, 4'b0001, 100);
    repeat (15) @(posedge clock);
    #2 req_valid[2] = 1'b1;
    @(posedge clock);
    #2 req_valid[2] = 1'b0;
    wait_idle(200);
    repeat (10) @(posedge clock); #2;
    checks++; if (gq.size() != base + 1) begin errors++; $display("FAIL withdrawn_strobes: %0d need %0d", gq.size(), base + 1); end
    checks++; if (ack_hi != abase + 1) begin errors++; $display("FAIL withdrawn_acks: %0d need %0d", ack_hi - abase, 1); end
  endtask

  task automatic test_reset_mid();
    int base = gq.size();
    req_data[7:0]  = 8'hC0;
    req_data[15:8] = 8'hC1;
    req_valid = 4'b0001;
    wait_strobes(base + 1, 4'b0000, 100);
    repeat (12) @(posedge clock);
    #2 req_valid = 4'b0011;
    repeat (3) @(posedge clock);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before: %b need 1", busy); end
    #3 reset = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: %b need 0", busy); end
    checks++; if (uart_tx_ready !== 1'b0 || req_ack !== 4'b0) begin errors++; $display("FAIL rmid_ready_ack: %b/%b need 0/0000", uart_tx_ready, req_ack); end
    checks++; if (grant_id !== 2'd0 || uart_tx_data !== 8'h00) begin errors++; $display("FAIL rmid_grant_data: %0d/%h need 0/00", grant_id, uart_tx_data); end
    repeat (50) @(posedge clock);
    #2 reset = 1'b1;
    base = gq.size();
    wait_strobes(base + 2, 4'b0011, 200);
    wait_idle(200);
    if (gq.size() >= base + 2) begin
      checks++; if (gq[base] !== 2'd0 || dq[base] !== 8'hC0) begin errors++; $display("FAIL rmid_first: id=%0d data=%h need 0/C0", gq[base], dq[base]); end
      checks++; if (gq[base+1] !== 2'd1 || dq[base+1] !== 8'hC1) begin errors++; $display("FAIL rmid_second: id=%0d data=%h need 1/C1", gq[base+1], dq[base+1]); end
    end
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    int base = gq.size();
    hang = 1'b1;
    req_data[7:0] = 8'h3C;
    req_valid = 4'b0001;
    wait_strobes(base + 1, 4'b0001, 100);
    repeat (99) @(posedge clock); #2;
    checks++; if (busy !== 1'b1 || timeout_err !== 1'b0) begin errors++; $display("FAIL to_early: busy=%b err=%b need 1/0", busy, timeout_err); end
    @(posedge clock); #2;
    checks++; if (busy !== 1'b0 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_fire: busy=%b err=%b need 0/1", busy, timeout_err); end
    repeat (20) @(posedge clock); #2;
    checks++; if (timeout_err !== 1'b1 || gq.size() != base + 1) begin errors++; $display("FAIL to_sticky: err=%b strobes=%0d need 1/%0d", timeout_err, gq.size(), base + 1); end
    apply_reset();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: %b need 0", timeout_err); end
  endtask
`else
  task automatic test_timeout();
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_tied: %b need 0", timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pointer_wrap();
    test_withdrawn();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among NUM_REQ byte requesters using round-robin arbitration.
- Sequences the UART load handshake: drives the byte and a rising-edge load strobe, then tracks the transmitter's done flag through busy and back to done before granting again.
- Sits between on-chip byte producers (debug, status, command responders) and the single UART TX instance; runs in the UART master clock domain.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- IDW, 2, width of grant_id; must equal ceil(log2(NUM_REQ)).
- TIMEOUT_CYCLES, 65535, watchdog limit in master clocks (used only with ARB_TIMEOUT_EN).

Ports:
- reset  input  1  asynchronous, active-low
- clock  input  1  master clock, same clock that feeds the UART
- req_valid  input  NUM_REQ  requester i has a byte pending; held until req_ack[i]
- req_data  input  8*NUM_REQ  byte for requester i in bits [8i+7:8i]; stable while req_valid[i]
- req_ack  output  NUM_REQ  one-cycle pulse: byte of requester i handed to the UART
- uart_tx_data  output  8  byte presented to the UART
- uart_tx_ready  output  1  load strobe to the UART; the UART loads on its rising edge
- uart_tx_done  input  1  UART done level, generated from the UART bit-clock domain
- busy  output  1  high whenever the FSM is not in IDLE
- grant_id  output  IDW  index of the last or current granted requester
- timeout_err  output  1  sticky watchdog flag; constant 0 without ARB_TIMEOUT_EN

Behaviour:
- Reset (async, active-low) forces all of the following:
  - FSM to IDLE, round-robin pointer to 0.
  - req_ack, uart_tx_ready, busy, timeout_err, grant_id and uart_tx_data to 0.
  - Synchroniser flops to 1 (treated as done).
- uart_tx_done passes through a 2-flop synchroniser to produce done_s. The FSM uses only done_s.
- FSM states:
  - IDLE: if done_s=1 and any req_valid, go to GRANT; otherwise stay.
  - GRANT (1 cycle):
    - Pick the first requester with req_valid set, searching upward from pointer, wrapping NUM_REQ-1 to 0.
    - Register its req_data into uart_tx_data and its index into grant_id.
    - Set pointer = winner+1 mod NUM_REQ.
    - Go to LOAD.
  - LOAD (1 cycle): uart_tx_ready=1 and req_ack[grant_id]=1; go to WAIT_BUSY.
  - WAIT_BUSY: uart_tx_ready=0; wait for done_s=0, then go to WAIT_DONE.
  - WAIT_DONE: wait for done_s=1, then go to IDLE.
- uart_tx_ready is high for exactly one clock per byte and is low for at least 4 clocks between strobes, which guarantees a fresh rising edge for each load.
- uart_tx_data holds its value from GRANT until the next GRANT.
- Latency: req_valid asserted in IDLE with done_s=1 gives GRANT on the next cycle and req_ack 2 clocks after the request is sampled.
- A requester whose req_valid falls before its grant is simply skipped; nothing is latched for it.
- req_valid deasserting after GRANT has no effect on the byte in flight.
- Back-to-back bytes from one requester: it keeps req_valid high after ack and is granted again only after other valid requesters have had a turn.
- Simultaneous requests: strict round-robin from the pointer; after reset the search starts at requester 0.
- Reset asserted mid-transfer aborts sequencing immediately. Any byte already in the UART finishes under the UART's own control.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro:
  - A 16-bit counter clears on entry to WAIT_BUSY and increments in WAIT_BUSY and WAIT_DONE.
  - When it reaches TIMEOUT_CYCLES, the FSM goes to IDLE and timeout_err is set.
  - timeout_err is cleared only by reset.
- Without the macro: no counter; WAIT_BUSY and WAIT_DONE wait indefinitely; timeout_err is tied to 0.

Test Plan:
- Single requester: NUM_REQ=4; req_valid=0001, req_data[7:0]=0x55; UART model holds done 1 → low 2 clocks after strobe → high 40 clocks later → one uart_tx_ready pulse, uart_tx_data=0x55, req_ack=0001 for 1 cycle, busy low again after done_s rises.
- Round-robin: req_valid=1111 held, data 0xA0..0xA3 → grant order 0,1,2,3,0; each req_ack pulse is exactly 1 cycle; strobes are separated by the full done cycle.
- Pointer wrap: after granting requester 3, raise only req_valid[1] and req_valid[3] → requester 1 is granted first, then 3.
- Withdrawn request: req_valid[2] pulses for 1 cycle while the FSM is in WAIT_DONE → no grant for requester 2, no uart_tx_ready pulse.
- Reset mid-transfer: assert reset in WAIT_DONE → busy, uart_tx_ready, req_ack, grant_id all 0 asynchronously; after release, pending req_valid[0] is granted first.
- ARB_TIMEOUT_EN with TIMEOUT_CYCLES=100: UART model holds done low forever → 100 clocks after entering WAIT_BUSY, FSM returns to IDLE, timeout_err=1 and stays 1 until reset.
